// File: rtl/smi_arbiter_if.sv
// Requester/engine bundle for smi_arbiter: requester side and SMI write-engine side.
// The arbiter uses the slave modport; the requesters and engine use the master modport.
interface smi_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [5*NREQ-1:0]    req_register;
  logic [16*NREQ-1:0]   req_content;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      err;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 smi_init;
  logic [4:0]           smi_register;
  logic [15:0]          smi_content;
  logic                 smi_ready;

  modport slave (
    input  req, req_register, req_content, smi_ready,
    output ack, err, grant, busy, smi_init, smi_register, smi_content
  );

  modport master (
    output req, req_register, req_content, smi_ready,
    input  ack, err, grant, busy, smi_init, smi_register, smi_content
  );
endinterface

// File: rtl/smi_arbiter.sv
// Round-robin arbiter sharing one SMI write engine between NREQ requesters.
// Optional per-phase watchdog enabled by defining SMI_ARB_TIMEOUT_EN.
module smi_arbiter #(
  parameter int NREQ           = 3,
  parameter int TIMEOUT_CYCLES = 16383
) (
  input  logic         clk,
  input  logic         reset,
  smi_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   grant_reg, grant_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic              busy_reg, busy_next;
  logic              smi_init_reg, smi_init_next;
  logic [4:0]        smi_register_reg, smi_register_next;
  logic [15:0]       smi_content_reg, smi_content_next;
  logic [IDXW-1:0]   last_reg, last_next;
`ifdef SMI_ARB_TIMEOUT_EN
  logic [NREQ-1:0]   err_reg, err_next;
  logic [15:0]       cnt_reg, cnt_next;
`endif

  logic [4:0]        reg_arr  [NREQ];
  logic [15:0]       cont_arr [NREQ];
  logic              pick_valid;
  logic [IDXW-1:0]   pick_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign reg_arr[gi]  = bus.req_register[5*gi +: 5];
      assign cont_arr[gi] = bus.req_content[16*gi +: 16];
    end
  endgenerate

  // Scan offsets from farthest to nearest so the nearest set request after last wins.
  always_comb begin
    logic [IDXW:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = {1'b0, last_reg} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NREQ))
        cand = cand - (IDXW+1)'(NREQ);
      if (bus.req[cand[IDXW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    grant_next        = grant_reg;
    ack_next          = '0;
    last_next         = last_reg;
    smi_register_next = smi_register_reg;
    smi_content_next  = smi_content_reg;
`ifdef SMI_ARB_TIMEOUT_EN
    err_next          = '0;
    cnt_next          = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.smi_ready && pick_valid) begin
          state_next           = ISSUE;
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          last_next            = pick_idx;
          smi_register_next    = reg_arr[pick_idx];
          smi_content_next     = cont_arr[pick_idx];
        end
      end
      ISSUE: begin
        state_next = WAIT_BUSY;
`ifdef SMI_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end
      WAIT_BUSY: begin
`ifdef SMI_ARB_TIMEOUT_EN
        cnt_next = cnt_reg + 16'd1;
`endif
        if (!bus.smi_ready) begin
          state_next = WAIT_DONE;
`ifdef SMI_ARB_TIMEOUT_EN
          cnt_next   = '0;
        end else if (cnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
          state_next = IDLE;
          err_next   = grant_reg;
          grant_next = '0;
`endif
        end
      end
      WAIT_DONE: begin
`ifdef SMI_ARB_TIMEOUT_EN
        cnt_next = cnt_reg + 16'd1;
`endif
        if (bus.smi_ready) begin
          state_next = DONE;
          ack_next   = grant_reg;
`ifdef SMI_ARB_TIMEOUT_EN
        end else if (cnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
          state_next = IDLE;
          err_next   = grant_reg;
          grant_next = '0;
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
    busy_next     = (state_next != IDLE);
    smi_init_next = (state_next == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      grant_reg        <= '0;
      ack_reg          <= '0;
      busy_reg         <= 1'b0;
      smi_init_reg     <= 1'b0;
      smi_register_reg <= '0;
      smi_content_reg  <= '0;
      last_reg         <= IDXW'(NREQ - 1);
`ifdef SMI_ARB_TIMEOUT_EN
      err_reg          <= '0;
      cnt_reg          <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      grant_reg        <= grant_next;
      ack_reg          <= ack_next;
      busy_reg         <= busy_next;
      smi_init_reg     <= smi_init_next;
      smi_register_reg <= smi_register_next;
      smi_content_reg  <= smi_content_next;
      last_reg         <= last_next;
`ifdef SMI_ARB_TIMEOUT_EN
      err_reg          <= err_next;
      cnt_reg          <= cnt_next;
`endif
    end
  end

  assign bus.grant        = grant_reg;
  assign bus.ack          = ack_reg;
  assign bus.busy         = busy_reg;
  assign bus.smi_init     = smi_init_reg;
  assign bus.smi_register = smi_register_reg;
  assign bus.smi_content  = smi_content_reg;
`ifdef SMI_ARB_TIMEOUT_EN
  assign bus.err          = err_reg;
`else
  assign bus.err          = '0;
`endif
endmodule

// File: tb/tb_smi_arbiter.sv
// Directed self-checking bench for smi_arbiter with a behavioural SMI engine model.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_smi_arbiter;
  localparam int NREQ = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  smi_arbiter_if #(.NREQ(NREQ)) bus ();

  smi_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Engine model: ready drops 2 cycles after init, rises eng_len cycles later.
  bit eng_stuck = 1'b0;
  int eng_len   = 64;

  initial begin
    int eng_state;
    int eng_cnt;
    eng_state     = 0;
    eng_cnt       = 0;
    bus.smi_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (eng_state)
        0: if (bus.smi_init && !eng_stuck) begin eng_cnt = 0; eng_state = 1; end
        1: begin
          eng_cnt++;
          if (eng_cnt == 2) begin bus.smi_ready = 1'b0; eng_cnt = 0; eng_state = 2; end
        end
        2: begin
          eng_cnt++;
          if (eng_cnt == eng_len) begin bus.smi_ready = 1'b1; eng_state = 0; end
        end
        default: eng_state = 0;
      endcase
    end
  end

  task automatic run_txn(input int max_cycles,
                         output logic [NREQ-1:0] ack_o, output logic [NREQ-1:0] err_o,
                         output logic [NREQ-1:0] grant_o, output int inits,
                         output int init_cyc, output int cyc, output logic onehot_ok);
    ack_o = '0; err_o = '0; grant_o = '0; inits = 0; init_cyc = -1; cyc = 0; onehot_ok = 1'b1;
    while (cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (bus.smi_init) begin inits++; init_cyc = cyc; end
      if (bus.grant != '0) begin
        grant_o = bus.grant;
        if (!$onehot(bus.grant)) onehot_ok = 1'b0;
      end
      if ((bus.ack | bus.err) != '0) begin ack_o = bus.ack; err_o = bus.err; break; end
    end
    $display("txn grant=%b ack=%b err=%b init_at=%0d end_at=%0d reg=%h content=%h",
             grant_o, ack_o, err_o, init_cyc, cyc, bus.smi_register, bus.smi_content);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_engine_busy(input string name);
    int n = 0;
    while (bus.smi_ready !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.smi_ready !== 1'b0) begin
      failures++; $display("FAIL %s_engine_start: smi_ready=%b required 0", name, bus.smi_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    bus.req          = 3'b111;
    bus.req_register = {5'h11, 5'h12, 5'h13};
    bus.req_content  = {16'h1111, 16'h2222, 16'h3333};
    repeat (3) @(negedge clk);
    checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL reset_grant: got %b required 000", bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL reset_ack: got %b required 000", bus.ack); end
    checks++; if (bus.err !== 3'b000) begin failures++; $display("FAIL reset_err: got %b required 000", bus.err); end
    checks++; if (bus.smi_init !== 1'b0) begin failures++; $display("FAIL reset_init: got %b required 0", bus.smi_init); end
    checks++; if (bus.smi_register !== 5'h00) begin failures++; $display("FAIL reset_register: got %h required 00", bus.smi_register); end
    checks++; if (bus.smi_content !== 16'h0000) begin failures++; $display("FAIL reset_content: got %h required 0000", bus.smi_content); end
    bus.req = '0;
    reset   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [NREQ-1:0] a, e, g; int inits, ic, cyc; logic oh;
    eng_len          = 64;
    bus.req_register = {5'h00, 5'h00, 5'h04};
    bus.req_content  = {16'h0000, 16'h0000, 16'h01E1};
    bus.req          = 3'b001;
    run_txn(200, a, e, g, inits, ic, cyc, oh);
    checks++; if (a !== 3'b001) begin failures++; $display("FAIL single_ack: got %b required 001", a); end
    checks++; if (e !== 3'b000) begin failures++; $display("FAIL single_err: got %b required 000", e); end
    checks++; if (inits != 1) begin failures++; $display("FAIL single_init_count: got %0d required 1", inits); end
    checks++; if (g !== 3'b001) begin failures++; $display("FAIL single_grant: got %b required 001", g); end
    checks++; if (bus.smi_register !== 5'h04) begin failures++; $display("FAIL single_register: got %h required 04", bus.smi_register); end
    checks++; if (bus.smi_content !== 16'h01E1) begin failures++; $display("FAIL single_content: got %h required 01e1", bus.smi_content); end
    checks++; if (cyc - ic != eng_len + 3) begin failures++; $display("FAIL single_latency: got %0d required %0d", cyc - ic, eng_len + 3); end
    bus.req = '0;
    @(negedge clk);
    checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL single_ack_width: got %b required 000", bus.ack); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b required 0", bus.busy); end
  endtask

  task automatic test_contention();
    int order [4] = '{0, 1, 2, 0};
    logic [4:0]  exp_reg  [3] = '{5'h00, 5'h04, 5'h01};
    logic [15:0] exp_cont [3] = '{16'h1200, 16'h01E1, 16'h0000};
    logic [NREQ-1:0] a, e, g, want; int inits, ic, cyc; logic oh;
    do_reset();
    eng_len          = 4;
    bus.req_register = {5'h01, 5'h04, 5'h00};
    bus.req_content  = {16'h0000, 16'h01E1, 16'h1200};
    bus.req          = 3'b111;
    for (int k = 0; k < 4; k++) begin
      want = 3'b001 << order[k];
      run_txn(100, a, e, g, inits, ic, cyc, oh);
      checks++; if (a !== want) begin failures++; $display("FAIL contention_ack%0d: got %b required %b", k, a, want); end
      checks++; if (g !== want || !oh) begin failures++; $display("FAIL contention_grant%0d: got %b onehot=%b required %b", k, g, oh, want); end
      checks++; if (inits != 1 || cyc - ic != eng_len + 3) begin failures++; $display("FAIL contention_timing%0d: inits=%0d latency=%0d required 1/%0d", k, inits, cyc - ic, eng_len + 3); end
      checks++; if (bus.smi_register !== exp_reg[order[k]] || bus.smi_content !== exp_cont[order[k]]) begin
        failures++; $display("FAIL contention_data%0d: got %h/%h required %h/%h", k, bus.smi_register, bus.smi_content, exp_reg[order[k]], exp_cont[order[k]]);
      end
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] a, e, g; int inits, ic, cyc; logic oh;
    do_reset();
    eng_len          = 4;
    bus.req_register = {5'h0C, 5'h02, 5'h0A};
    bus.req_content  = {16'hCCCC, 16'hABCD, 16'hAAAA};
    bus.req          = 3'b010;
    run_txn(100, a, e, g, inits, ic, cyc, oh);
    checks++; if (a !== 3'b010) begin failures++; $display("FAIL fair_first: got %b required 010", a); end
    bus.req = 3'b101;
    run_txn(100, a, e, g, inits, ic, cyc, oh);
    checks++; if (a !== 3'b100) begin failures++; $display("FAIL fair_second: got %b required 100", a); end
    checks++; if (bus.smi_register !== 5'h0C || bus.smi_content !== 16'hCCCC) begin
      failures++; $display("FAIL fair_second_data: got %h/%h required 0c/cccc", bus.smi_register, bus.smi_content);
    end
    bus.req = 3'b001;
    run_txn(100, a, e, g, inits, ic, cyc, oh);
    checks++; if (a !== 3'b001) begin failures++; $display("FAIL fair_third: got %b required 001", a); end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [NREQ-1:0] a, e, g; int inits, ic, cyc; logic oh; int spurious;
    do_reset();
    eng_len          = 64;
    bus.req_register = {5'h00, 5'h09, 5'h07};
    bus.req_content  = {16'h0000, 16'h0909, 16'h5555};
    bus.req          = 3'b001;
    wait_engine_busy("midreset");
    reset   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    checks++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_grant_busy: got %b/%b required 000/0", bus.grant, bus.busy); end
    checks++; if (bus.ack !== 3'b000 || bus.err !== 3'b000) begin failures++; $display("FAIL midreset_ack_err: got %b/%b required 000/000", bus.ack, bus.err); end
    checks++; if (bus.smi_init !== 1'b0 || bus.smi_register !== 5'h00 || bus.smi_content !== 16'h0000) begin
      failures++; $display("FAIL midreset_engine_side: got %b/%h/%h required 0/00/0000", bus.smi_init, bus.smi_register, bus.smi_content);
    end
    reset    = 1'b1;
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if ((bus.ack | bus.err) != '0) spurious++;
    end
    checks++; if (spurious != 0) begin failures++; $display("FAIL midreset_no_pulse: got %0d pulses required 0", spurious); end
    bus.req = 3'b010;
    run_txn(300, a, e, g, inits, ic, cyc, oh);
    checks++; if (a !== 3'b010) begin failures++; $display("FAIL midreset_next_ack: got %b required 010", a); end
    checks++; if (bus.smi_register !== 5'h09 || bus.smi_content !== 16'h0909) begin
      failures++; $display("FAIL midreset_next_data: got %h/%h required 09/0909", bus.smi_register, bus.smi_content);
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] a, e, g; int inits, ic, cyc; logic oh;
    do_reset();
    eng_stuck        = 1'b1;
    bus.req_register = {5'h1A, 5'h00, 5'h00};
    bus.req_content  = {16'hC0DE, 16'h0000, 16'h0000};
    bus.req          = 3'b100;
    run_txn(60, a, e, g, inits, ic, cyc, oh);
    checks++; if (a !== 3'b000) begin failures++; $display("FAIL timeout_ack: got %b required 000", a); end
`ifdef SMI_ARB_TIMEOUT_EN
    checks++; if (e !== 3'b100) begin failures++; $display("FAIL timeout_err: got %b required 100", e); end
    checks++; if (cyc - ic != 21) begin failures++; $display("FAIL timeout_delay: got %0d required 21", cyc - ic); end
    checks++; if (bus.busy !== 1'b0 || bus.grant !== 3'b000) begin failures++; $display("FAIL timeout_idle: busy=%b grant=%b required 0/000", bus.busy, bus.grant); end
    checks++; if (bus.smi_register !== 5'h1A || bus.smi_content !== 16'hC0DE) begin
      failures++; $display("FAIL timeout_data: got %h/%h required 1a/c0de", bus.smi_register, bus.smi_content);
    end
    bus.req = '0;
    @(negedge clk);
    checks++; if (bus.err !== 3'b000) begin failures++; $display("FAIL timeout_err_width: got %b required 000", bus.err); end
`else
    checks++; if (e !== 3'b000 || bus.err !== 3'b000) begin failures++; $display("FAIL timeout_err_off: got %b required 000", e); end
    checks++; if (bus.busy !== 1'b1 || bus.grant !== 3'b100) begin failures++; $display("FAIL timeout_stays_waiting: busy=%b grant=%b required 1/100", bus.busy, bus.grant); end
    checks++; if (inits != 1) begin failures++; $display("FAIL timeout_init_count: got %0d required 1", inits); end
`endif
    eng_stuck = 1'b0;
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] a, e, g; int inits, ic, cyc; logic oh;
    do_reset();
    eng_len          = 16;
    bus.req_register = {5'h00, 5'h00, 5'h04};
    bus.req_content  = {16'h0000, 16'h0000, 16'h01E1};
    bus.req          = 3'b001;
    wait_engine_busy("stable");
    bus.req_register = {5'h00, 5'h00, 5'h1F};
    bus.req_content  = {16'h0000, 16'h0000, 16'hFFFF};
    @(negedge clk);
    checks++; if (bus.smi_content !== 16'h01E1 || bus.smi_register !== 5'h04) begin
      failures++; $display("FAIL stable_during_wait: got %h/%h required 04/01e1", bus.smi_register, bus.smi_content);
    end
    run_txn(100, a, e, g, inits, ic, cyc, oh);
    checks++; if (a !== 3'b001 || bus.smi_content !== 16'h01E1) begin
      failures++; $display("FAIL stable_at_ack: ack=%b content=%h required 001/01e1", a, bus.smi_content);
    end
    run_txn(100, a, e, g, inits, ic, cyc, oh);
    checks++; if (a !== 3'b001 || g !== 3'b001) begin failures++; $display("FAIL b2b_regrant: ack=%b grant=%b required 001/001", a, g); end
    checks++; if (bus.smi_register !== 5'h1F || bus.smi_content !== 16'hFFFF) begin
      failures++; $display("FAIL b2b_new_data: got %h/%h required 1f/ffff", bus.smi_register, bus.smi_content);
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  initial begin
    bus.req          = '0;
    bus.req_register = '0;
    bus.req_content  = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_fairness();
    test_mid_reset();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
